vga_sync_rx: RTL
================

Name: vga_sync_rx

Overview:
- Receive-side counterpart of the VGA timing generator.
- Takes raw active-low hsync and vsync plus DE from a video source, and recovers the pixel column/row position of each active pixel.
- Measures line length, declares timing lock, and flags timing violations.
- Sits in the Pipeline_test_FPGA loopback path: it checks generator output on-chip and feeds frame-capture/compare logic.

Parameters:
- H_TOTAL, 800, expected clocks per line (hsync fall to hsync fall).
- H_ACTIVE, 640, expected DE-high clocks per line.
- V_ACTIVE, 480, expected active lines per frame.
- LOCK_LINES, 4, consecutive correct-length lines required to enter LOCKED (range 1..15).
- CNT_W, 10, width of all internal counters and count outputs.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, synchronous, active-low.
- hsync_in  in  1  horizontal sync, active-low.
- vsync_in  in  1  vertical sync, active-low.
- de_in  in  1  data enable, high during active video.
- pix_valid  out  1  registered DE; high when pix_col/pix_row describe a live pixel.
- pix_col  out  CNT_W  column index of current active pixel, 0-based.
- pix_row  out  CNT_W  row index of current active line, 0-based.
- line_start  out  1  one-cycle pulse on each detected hsync falling edge.
- frame_start  out  1  one-cycle pulse on each detected vsync falling edge.
- locked  out  1  high while the FSM is in LOCKED.
- line_len  out  CNT_W  last measured hsync-to-hsync period in clocks.
- err_hlen  out  1  one-cycle pulse: line length mismatch while LOCKED.
- err_hactive  out  1  one-cycle pulse: DE width not equal to H_ACTIVE while LOCKED.
- err_vactive  out  1  one-cycle pulse at frame_start: previous frame row count not equal to V_ACTIVE while LOCKED.

Behaviour:
- Input stage:
  - hsync_in, vsync_in and de_in are registered twice (s1, s2).
  - Edges are detected on s2 against s1.
  - All outputs are registered, so total latency from input to output is 3 clk.
- Reset (rst=0 at a clk edge):
  - pix_valid=0, pix_col=0, pix_row=0.
  - line_start=0, frame_start=0, locked=0, line_len=0.
  - All err_* outputs 0.
  - FSM=SEARCH, hcnt=0, match_cnt=0, row_cnt=0.
  - Sync registers reset to idle levels: hsync=1, vsync=1, de=0.
  - A mid-frame reset discards all measurement; lock is reacquired from scratch.
- hcnt:
  - Increments every clk.
  - On an hsync fall: line_len<=hcnt+1, then hcnt<=0.
  - Saturates at 2^CNT_W-1. At saturation the FSM goes to SEARCH and line_len is not updated.
- pix_col:
  - 0 on the first DE-high cycle, +1 each subsequent DE-high cycle.
  - Held at last value while DE is low; reloaded to 0 at the next DE rise.
- pix_row and row_cnt:
  - row_cnt increments on each DE falling edge; pix_row follows row_cnt.
  - vsync fall clears row_cnt to 0. A vsync fall takes priority over a coincident DE fall.
- FSM states SEARCH, MEASURE, LOCKED (one-hot):
  - SEARCH: on hsync fall -> MEASURE, match_cnt=0. The first edge only starts a measurement.
  - MEASURE: on each hsync fall, if hcnt+1==H_TOTAL then match_cnt+1, else match_cnt=0.
  - MEASURE: when match_cnt+1 reaches LOCK_LINES -> LOCKED.
  - LOCKED: on an hsync fall with length not equal to H_TOTAL, pulse err_hlen -> SEARCH.
  - LOCKED: hcnt saturation -> SEARCH with no err pulse.
- DE-width check (LOCKED only): at a DE fall, if pix_col+1 != H_ACTIVE, pulse err_hactive. The FSM state is unchanged.
- Row-count check (LOCKED only): at a vsync fall, if row_cnt != V_ACTIVE and at least one full frame has been seen since lock, pulse err_vactive.
- Simultaneous hsync and vsync falls: line_start and frame_start both pulse in the same cycle.
- Widths: all compares use CNT_W-bit unsigned arithmetic. H_TOTAL and V_ACTIVE must fit in CNT_W bits.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the 640x480@60 constants (pulse 96, back porch 48, active 640, front porch 16, total 800; vertical 2/33/480/10, total 525);
  - the state encodings.
- The generator and this receiver share this package.
- One natural sub-module, sync_edge_det: two-flop synchroniser plus rise/fall pulse outputs. It is instantiated three times.

Test Plan:
- Drive the generator's 800-clk line timing (hsync low 96, DE high 640) -> locked rises 3 clk after the 5th hsync fall; line_len=800; no err pulses.
- Locked, then one line shortened to 799 clk -> err_hlen single pulse, locked=0 the following cycle; relock after 4 further good lines.
- DE high for 639 clk on one line while locked -> err_hactive pulse; locked stays 1; pix_col reads 638 on the last valid pixel.
- Full 525-line frame with 480 DE lines -> pix_row runs 0..479; at the next vsync fall frame_start pulses, pix_row=0, no err_vactive. Repeat with 479 lines -> err_vactive pulse.
- Hold hsync_in high for 1100 clk while locked -> locked=0 at hcnt saturation (1023); no err_hlen; line_len retains 800.
- Assert rst=0 mid-line at pixel 300, release -> all outputs 0 on the next edge; relock requires 4 good lines.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants and receiver state encodings shared by generator and receiver
package vga_timing_pkg;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int H_ACT  = 640;
    localparam int H_FP   = 16;
    localparam int H_TOT  = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;
    localparam int V_ACT  = 480;
    localparam int V_FP   = 10;
    localparam int V_TOT  = V_SYNC + V_BP + V_ACT + V_FP;
    typedef enum logic [2:0] {
        SEARCH  = 3'b001,
        MEASURE = 3'b010,
        LOCKED  = 3'b100
    } rx_state_e;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: two-flop synchroniser with registered rise/fall pulses aligned to the synchronised level
module sync_edge_det #(
    parameter logic IDLE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);
    logic s1_q, s1_d, s2_q, s2_d, rise_q, rise_d, fall_q, fall_d;
    // shift the input through both stages and flag an edge between them
    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        rise_d = s1_q & ~s2_q;
        fall_d = ~s1_q & s2_q;
    end
    // stages reset to the idle level so reset never creates a false edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q   <= IDLE;
            s2_q   <= IDLE;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end
    assign lvl  = s2_q;
    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel position from hsync/vsync/DE, measures line length, tracks lock and flags timing errors
module vga_sync_rx
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL    = H_TOT,
    parameter int H_ACTIVE   = H_ACT,
    parameter int V_ACTIVE   = V_ACT,
    parameter int LOCK_LINES = 4,
    parameter int CNT_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             de_in,
    output logic             pix_valid,
    output logic [CNT_W-1:0] pix_col,
    output logic [CNT_W-1:0] pix_row,
    output logic             line_start,
    output logic             frame_start,
    output logic             locked,
    output logic [CNT_W-1:0] line_len,
    output logic             err_hlen,
    output logic             err_hactive,
    output logic             err_vactive
);
    localparam logic [CNT_W-1:0] H_TOT_C = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       LOCK_C  = 4'(LOCK_LINES);

    logic hs_lvl, hs_rise, hs_fall, vs_lvl, vs_rise, vs_fall, de_lvl, de_rise, de_fall;
    logic unused;

    sync_edge_det #(.IDLE(1'b1)) u_hs (.clk(clk), .rst(rst), .din(hsync_in), .lvl(hs_lvl), .rise(hs_rise), .fall(hs_fall));
    sync_edge_det #(.IDLE(1'b1)) u_vs (.clk(clk), .rst(rst), .din(vsync_in), .lvl(vs_lvl), .rise(vs_rise), .fall(vs_fall));
    sync_edge_det #(.IDLE(1'b0)) u_de (.clk(clk), .rst(rst), .din(de_in), .lvl(de_lvl), .rise(de_rise), .fall(de_fall));

    assign unused = ^{hs_lvl, hs_rise, vs_lvl, vs_rise};

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, line_len_q, line_len_d, pix_col_q, pix_col_d, row_cnt_q, row_cnt_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic             pix_valid_q, pix_valid_d, line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic             err_hlen_q, err_hlen_d, err_hactive_q, err_hactive_d, err_vactive_q, err_vactive_d;
    logic             frame_seen_q, frame_seen_d;
    logic             sat, len_ok, is_locked;
    logic [CNT_W-1:0] hcnt_inc;
    logic [3:0]       match_inc;

    // counters, lock FSM and error checks; a saturated hcnt overrides any edge and forces a fresh search
    always_comb begin
        sat           = hcnt_q == CNT_MAX;
        hcnt_inc      = hcnt_q + 1'b1;
        len_ok        = hcnt_inc == H_TOT_C;
        match_inc     = match_cnt_q + 1'b1;
        is_locked     = state_q == LOCKED;
        hcnt_d        = hs_fall ? '0 : (sat ? hcnt_q : hcnt_inc);
        line_len_d    = (hs_fall && !sat) ? hcnt_inc : line_len_q;
        pix_valid_d   = de_lvl;
        pix_col_d     = de_rise ? '0 : (de_lvl ? pix_col_q + 1'b1 : pix_col_q);
        row_cnt_d     = vs_fall ? '0 : (de_fall ? row_cnt_q + 1'b1 : row_cnt_q);
        line_start_d  = hs_fall;
        frame_start_d = vs_fall;
        err_hactive_d = is_locked && de_fall && (pix_col_q + 1'b1 != H_ACT_C);
        err_vactive_d = is_locked && vs_fall && frame_seen_q && (row_cnt_q != V_ACT_C);
        frame_seen_d  = !is_locked ? 1'b0 : (vs_fall ? 1'b1 : frame_seen_q);
        state_d       = state_q;
        match_cnt_d   = match_cnt_q;
        err_hlen_d    = 1'b0;
        if (sat) begin
            state_d = SEARCH;
        end else if (hs_fall) begin
            case (state_q)
                SEARCH: begin
                    state_d     = MEASURE;
                    match_cnt_d = '0;
                end
                MEASURE: begin
                    match_cnt_d = len_ok ? match_inc : '0;
                    state_d     = (len_ok && match_inc >= LOCK_C) ? LOCKED : MEASURE;
                end
                LOCKED: begin
                    state_d    = len_ok ? LOCKED : SEARCH;
                    err_hlen_d = !len_ok;
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // state and output registers; reset discards all measurement
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= SEARCH;
            hcnt_q        <= '0;
            line_len_q    <= '0;
            pix_col_q     <= '0;
            row_cnt_q     <= '0;
            match_cnt_q   <= '0;
            pix_valid_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            err_hlen_q    <= 1'b0;
            err_hactive_q <= 1'b0;
            err_vactive_q <= 1'b0;
            frame_seen_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            line_len_q    <= line_len_d;
            pix_col_q     <= pix_col_d;
            row_cnt_q     <= row_cnt_d;
            match_cnt_q   <= match_cnt_d;
            pix_valid_q   <= pix_valid_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            err_hlen_q    <= err_hlen_d;
            err_hactive_q <= err_hactive_d;
            err_vactive_q <= err_vactive_d;
            frame_seen_q  <= frame_seen_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_col     = pix_col_q;
    assign pix_row     = row_cnt_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign locked      = is_locked;
    assign line_len    = line_len_q;
    assign err_hlen    = err_hlen_q;
    assign err_hactive = err_hactive_q;
    assign err_vactive = err_vactive_q;
endmodule
